dma_chan_ctl: RTL and testbench

//  CPU-programmed DMA channel sequencer directly upstream of the DMA bus-transfer engine.

---
 rtl/dma_chan_ctl_pkg.sv | 30 +++
 rtl/dma_chan_ctl_if.sv | 29 ++
 rtl/dma_chan_ctl_addr_gen.sv | 40 ++++
 rtl/dma_chan_ctl.sv | 143 ++++++++++++++
 tb/tb_dma_chan_ctl.sv | 213 +++++++++++++++++++++
 5 files changed

// File: rtl/dma_chan_ctl_pkg.sv
// Shared types and register map for the DMA channel sequencer.
// Register offsets, CTRL/STATUS bit positions and FSM state encoding.
package dma_chan_ctl_pkg;

  typedef enum logic [2:0] {
    ST_IDLE     = 3'd0,
    ST_ISSUE    = 3'd1,
    ST_WAIT_EOP = 3'd2,
    ST_ADVANCE  = 3'd3,
    ST_DONE     = 3'd4
  } state_t;

  localparam logic [2:0] REG_SRC    = 3'd0;
  localparam logic [2:0] REG_DST    = 3'd1;
  localparam logic [2:0] REG_LEN    = 3'd2;
  localparam logic [2:0] REG_CTRL   = 3'd3;
  localparam logic [2:0] REG_STATUS = 3'd4;
  localparam logic [2:0] REG_REMAIN = 3'd5;

  localparam int CTRL_START   = 0;
  localparam int CTRL_MODE_LO = 1;
  localparam int CTRL_MODE_HI = 2;
  localparam int CTRL_IE      = 3;
  localparam int CTRL_ABORT   = 4;

  localparam int STAT_BUSY    = 0;
  localparam int STAT_DONE    = 1;
  localparam int STAT_ABORTED = 2;

endpackage

// File: rtl/dma_chan_ctl_if.sv
// CPU register port and engine request/complete port of the DMA channel.
// Engine handshake: dreq_ low for exactly one clk requests one word; the engine answers
// later with eop_ low, which the channel samples only while waiting for that word.
interface dma_chan_ctl_if #(
  parameter int ADDR_W = 16,
  parameter int DATA_W = 16
);
  logic              cs;
  logic              we;
  logic [2:0]        regsel;
  logic [DATA_W-1:0] wdata;
  logic [DATA_W-1:0] rdata;
  logic [ADDR_W-1:0] dsaddr;
  logic [ADDR_W-1:0] ddaddr;
  logic [1:0]        dmode;
  logic              dreq_;
  logic              eop_;
  logic              irq;

  modport master (
    output cs, we, regsel, wdata, eop_,
    input  rdata, dsaddr, ddaddr, dmode, dreq_, irq
  );

  modport slave (
    input  cs, we, regsel, wdata, eop_,
    output rdata, dsaddr, ddaddr, dmode, dreq_, irq
  );
endinterface

// File: rtl/dma_chan_ctl_addr_gen.sv
// Source/destination address counters and remaining-word counter for one DMA channel.
module dma_chan_ctl_addr_gen #(
  parameter int ADDR_W = 16,
  parameter int LEN_W  = 8
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              src_ld,
  input  logic              dst_ld,
  input  logic [ADDR_W-1:0] ld_data,
  input  logic              rem_ld,
  input  logic [LEN_W-1:0]  rem_data,
  input  logic              step,
  input  logic              src_inc,
  input  logic              dst_inc,
  output logic [ADDR_W-1:0] src,
  output logic [ADDR_W-1:0] dst,
  output logic [LEN_W-1:0]  remain,
  output logic              rem_last
);

  // High when the current step takes the count to zero.
  assign rem_last = (remain == LEN_W'(1));

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      src    <= '0;
      dst    <= '0;
      remain <= '0;
    end else begin
      if (src_ld)    src <= ld_data;
      else if (step) src <= src + ADDR_W'(src_inc);
      if (dst_ld)    dst <= ld_data;
      else if (step) dst <= dst + ADDR_W'(dst_inc);
      if (rem_ld)    remain <= rem_data;
      else if (step) remain <= remain - LEN_W'(1);
    end
  end

endmodule

// File: rtl/dma_chan_ctl.sv
// CPU-programmed DMA channel sequencer: one single-word request per word, irq at block end.
// Optional feature macro: DMACH_ABORT_EN (CTRL.abort / STATUS.aborted).
module dma_chan_ctl
  import dma_chan_ctl_pkg::*;
#(
  parameter int ADDR_W = 16,
  parameter int DATA_W = 16,
  parameter int LEN_W  = 8
) (
  input  logic           clk,
  input  logic           reset,
  dma_chan_ctl_if.slave  bus,
  output state_t         dbg_state
);

  state_t            state, next_state;
  logic [LEN_W-1:0]  len_reg;
  logic [1:0]        mode;
  logic              ie, done;
  logic              abort_flag, aborted, abort_now;
  logic [ADDR_W-1:0] src, dst;
  logic [LEN_W-1:0]  remain;
  logic              rem_last, busy, cpu_wr, cpu_rd, ctrl_wr, start_wr, w1c_done, done_set;
  logic [DATA_W-1:0] rd_mux, rdata_q;

  assign busy     = (state == ST_ISSUE) || (state == ST_WAIT_EOP) || (state == ST_ADVANCE);
  assign cpu_wr   = bus.cs & bus.we;
  assign cpu_rd   = bus.cs & ~bus.we;
  assign ctrl_wr  = cpu_wr && (bus.regsel == REG_CTRL);
  assign start_wr = ctrl_wr && bus.wdata[CTRL_START] && !busy;
  assign w1c_done = cpu_wr && (bus.regsel == REG_STATUS) && bus.wdata[STAT_DONE];
  assign done_set = (start_wr && (len_reg == '0)) ||
                    ((state == ST_ADVANCE) && (next_state == ST_DONE));

  dma_chan_ctl_addr_gen #(.ADDR_W(ADDR_W), .LEN_W(LEN_W)) u_addr_gen (
    .clk      (clk),
    .reset    (reset),
    .src_ld   (cpu_wr && (bus.regsel == REG_SRC) && !busy),
    .dst_ld   (cpu_wr && (bus.regsel == REG_DST) && !busy),
    .ld_data  (bus.wdata[ADDR_W-1:0]),
    .rem_ld   (start_wr),
    .rem_data (len_reg),
    .step     (state == ST_ADVANCE),
    .src_inc  (mode[0]),
    .dst_inc  (mode[1]),
    .src      (src),
    .dst      (dst),
    .remain   (remain),
    .rem_last (rem_last)
  );

  always_ff @(posedge clk or posedge reset) begin
    if (reset) state <= ST_IDLE;
    else       state <= next_state;
  end

  always_comb begin
    next_state = state;
    case (state)
      ST_IDLE, ST_DONE: begin
        if (start_wr)             next_state = (len_reg == '0) ? ST_DONE : ST_ISSUE;
        else if (state == ST_DONE) next_state = ST_IDLE;
      end
      ST_ISSUE:    next_state = ST_WAIT_EOP;
      ST_WAIT_EOP: if (!bus.eop_) next_state = ST_ADVANCE;
      ST_ADVANCE:  next_state = (rem_last || abort_now) ? ST_DONE : ST_ISSUE;
      default:     next_state = ST_IDLE;
    endcase
  end

`ifdef DMACH_ABORT_EN
  logic abort_wr;
  assign abort_wr  = ctrl_wr && bus.wdata[CTRL_ABORT] && busy;
  assign abort_now = abort_flag | abort_wr;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      abort_flag <= 1'b0;
      aborted    <= 1'b0;
    end else if (start_wr) begin
      abort_flag <= 1'b0;
      aborted    <= 1'b0;
    end else begin
      if (abort_wr) abort_flag <= 1'b1;
      if ((state == ST_ADVANCE) && abort_now) aborted <= 1'b1;
    end
  end
`else
  assign abort_flag = 1'b0;
  assign aborted    = 1'b0;
  assign abort_now  = 1'b0;
`endif

  // Set beats W1C when both land on the same edge.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      len_reg <= '0;
      mode    <= '0;
      ie      <= 1'b0;
      done    <= 1'b0;
      rdata_q <= '0;
    end else begin
      if (cpu_wr && (bus.regsel == REG_LEN) && !busy) len_reg <= bus.wdata[LEN_W-1:0];
      if (ctrl_wr) begin
        ie <= bus.wdata[CTRL_IE];
        if (!busy) mode <= bus.wdata[CTRL_MODE_HI:CTRL_MODE_LO];
      end
      if (done_set)                done <= 1'b1;
      else if (start_wr || w1c_done) done <= 1'b0;
      if (cpu_rd) rdata_q <= rd_mux;
    end
  end

  always_comb begin
    rd_mux = '0;
    case (bus.regsel)
      REG_SRC:    rd_mux = DATA_W'(src);
      REG_DST:    rd_mux = DATA_W'(dst);
      REG_LEN:    rd_mux = DATA_W'(len_reg);
      REG_CTRL: begin
        rd_mux[CTRL_ABORT]                = abort_flag;
        rd_mux[CTRL_IE]                   = ie;
        rd_mux[CTRL_MODE_HI:CTRL_MODE_LO] = mode;
      end
      REG_STATUS: begin
        rd_mux[STAT_ABORTED] = aborted;
        rd_mux[STAT_DONE]    = done;
        rd_mux[STAT_BUSY]    = busy;
      end
      REG_REMAIN: rd_mux = DATA_W'(remain);
      default:    rd_mux = '0;
    endcase
  end

  assign bus.rdata  = rdata_q;
  assign bus.dsaddr = src;
  assign bus.ddaddr = dst;
  assign bus.dmode  = mode;
  assign bus.dreq_  = (state != ST_ISSUE);
  assign bus.irq    = done & ie;
  assign dbg_state  = state;

endmodule

// File: tb/tb_dma_chan_ctl.sv
// Scoreboard bench for dma_chan_ctl: read data and per-word requests checked by monitors.
module tb_dma_chan_ctl;
  import dma_chan_ctl_pkg::*;

  logic   clk = 1'b0;
  logic   reset = 1'b1;
  state_t dbg_state;
  logic   engine_en = 1'b1;
  int     checks = 0;
  int     errors = 0;

  logic [15:0] exp_rd_q[$];
  string       rd_name_q[$];
  logic [33:0] exp_req_q[$];
  logic        rd_seen = 1'b0;
  logic        prev_low = 1'b0;

  dma_chan_ctl_if #(.ADDR_W(16), .DATA_W(16)) bus ();

  dma_chan_ctl #(.ADDR_W(16), .DATA_W(16), .LEN_W(8)) dut (
    .clk       (clk),
    .reset     (reset),
    .bus       (bus),
    .dbg_state (dbg_state)
  );

  // Clock / reset
  always #5 clk = ~clk;

  task automatic check(input string name, input logic [33:0] act, input logic [33:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h expected=%h", name, act, exp);
    end
  endtask

  // Drivers: called at posedge+1, return at posedge+1
  task automatic cpu_write(input logic [2:0] a, input logic [15:0] d);
    bus.cs = 1'b1; bus.we = 1'b1; bus.regsel = a; bus.wdata = d;
    @(posedge clk); #1;
    bus.cs = 1'b0; bus.we = 1'b0;
  endtask

  task automatic cpu_read(input logic [2:0] a, input logic [15:0] exp, input string name);
    exp_rd_q.push_back(exp);
    rd_name_q.push_back(name);
    bus.cs = 1'b1; bus.we = 1'b0; bus.regsel = a;
    @(posedge clk); #1;
    bus.cs = 1'b0;
  endtask

  task automatic push_req(input logic [15:0] s, input logic [15:0] d, input logic [1:0] m);
    exp_req_q.push_back({s, d, m});
  endtask

  task automatic wait_state(input state_t st, input string name);
    for (int i = 0; i < 300; i++) begin
      if (dbg_state == st) return;
      @(posedge clk); #1;
    end
    check(name, 34'(dbg_state), 34'(st));
  endtask

  // Engine model: eop_ low for one clk, a few clk after each request
  always begin
    @(negedge clk);
    if (engine_en && !bus.dreq_) begin
      repeat (3) @(posedge clk);
      #1 bus.eop_ = 1'b0;
      @(posedge clk);
      #1 bus.eop_ = 1'b1;
    end
  end

  // Monitor: read data and word requests against the expected queues
  always @(negedge clk) begin
    if (rd_seen) begin
      if (exp_rd_q.size() == 0) check("rd_unexpected", 34'(bus.rdata), 34'h3_ffff_ffff);
      else check(rd_name_q.pop_front(), 34'(bus.rdata), 34'(exp_rd_q.pop_front()));
    end
    rd_seen <= bus.cs & ~bus.we;
    if (prev_low) check("dreq_pulse_width", 34'(bus.dreq_), 34'd1);
    if (!bus.dreq_ && !prev_low) begin
      if (exp_req_q.size() == 0) check("dreq_unexpected", {bus.dsaddr, bus.ddaddr, bus.dmode}, 34'h3_ffff_ffff);
      else check("dreq_addr", {bus.dsaddr, bus.ddaddr, bus.dmode}, exp_req_q.pop_front());
    end
    prev_low <= !bus.dreq_;
  end

  initial begin
    bus.cs = 1'b0; bus.we = 1'b0; bus.regsel = 3'd0; bus.wdata = 16'h0; bus.eop_ = 1'b1;
    repeat (3) @(posedge clk);
    #1 reset = 1'b0;

    // Reset state
    check("rst_dreq", 34'(bus.dreq_), 34'd1);
    check("rst_irq", 34'(bus.irq), 34'd0);
    check("rst_addr", {bus.dsaddr, bus.ddaddr, bus.dmode}, 34'd0);
    check("rst_rdata", 34'(bus.rdata), 34'd0);
    cpu_read(REG_SRC, 16'h0, "rst_src");
    cpu_read(REG_STATUS, 16'h0, "rst_status");
    cpu_read(REG_CTRL, 16'h0, "rst_ctrl");

    // Three words, source increments, destination fixed, ie=1
    cpu_write(REG_SRC, 16'h0100);
    cpu_write(REG_DST, 16'h8000);
    cpu_write(REG_LEN, 16'd3);
    push_req(16'h0100, 16'h8000, 2'b01);
    push_req(16'h0101, 16'h8000, 2'b01);
    push_req(16'h0102, 16'h8000, 2'b01);
    cpu_write(REG_CTRL, 16'h000B);
    cpu_read(REG_STATUS, 16'h0001, "busy_status");
    wait_state(ST_IDLE, "t1_timeout");
    cpu_read(REG_STATUS, 16'h0002, "t1_status");
    cpu_read(REG_REMAIN, 16'h0000, "t1_remain");
    cpu_read(REG_SRC, 16'h0103, "t1_src");
    cpu_read(REG_DST, 16'h8000, "t1_dst");
    cpu_read(REG_CTRL, 16'h000A, "t1_ctrl");
    check("t1_irq", 34'(bus.irq), 34'd1);
    cpu_write(REG_STATUS, 16'h0002);
    cpu_read(REG_STATUS, 16'h0000, "t1_w1c");
    check("t1_irq_clr", 34'(bus.irq), 34'd0);

    // Zero length: done one cycle later, no request, irq follows ie
    cpu_write(REG_LEN, 16'd0);
    cpu_write(REG_CTRL, 16'h0009);
    check("len0_irq_ie1", 34'(bus.irq), 34'd1);
    cpu_write(REG_STATUS, 16'h0002);
    cpu_write(REG_CTRL, 16'h0001);
    check("len0_irq_ie0", 34'(bus.irq), 34'd0);
    cpu_read(REG_STATUS, 16'h0002, "len0_status");

    // Source wrap with both addresses incrementing
    cpu_write(REG_SRC, 16'hFFFF);
    cpu_write(REG_DST, 16'h0010);
    cpu_write(REG_LEN, 16'd2);
    push_req(16'hFFFF, 16'h0010, 2'b11);
    push_req(16'h0000, 16'h0011, 2'b11);
    cpu_write(REG_CTRL, 16'h0007);
    wait_state(ST_IDLE, "t3_timeout");
    cpu_read(REG_SRC, 16'h0001, "wrap_src");
    cpu_read(REG_DST, 16'h0012, "wrap_dst");
    cpu_read(REG_REMAIN, 16'h0000, "wrap_remain");

    // Writes while busy ignored; W1C on the done-set edge loses
    cpu_write(REG_SRC, 16'h0200);
    cpu_write(REG_DST, 16'h0300);
    cpu_write(REG_LEN, 16'd4);
    for (int k = 0; k < 4; k++) push_req(16'h0200 + 16'(k), 16'h0300, 2'b01);
    cpu_write(REG_CTRL, 16'h0003);
    cpu_write(REG_SRC, 16'h0055);
    cpu_write(REG_LEN, 16'd7);
    cpu_write(REG_CTRL, 16'h0007);
    for (int k = 0; k < 4; k++) begin
      wait_state(ST_ADVANCE, "t4_adv_timeout");
      if (k < 3) begin @(posedge clk); #1; end
    end
    cpu_write(REG_STATUS, 16'h0002);
    cpu_read(REG_STATUS, 16'h0002, "w1c_vs_set");
    cpu_read(REG_LEN, 16'd4, "busy_len");
    cpu_read(REG_SRC, 16'h0204, "busy_src");
    cpu_read(REG_CTRL, 16'h0002, "busy_ctrl");

    // Reset while waiting for the engine
    engine_en = 1'b0;
    cpu_write(REG_SRC, 16'h0040);
    cpu_write(REG_DST, 16'h0050);
    cpu_write(REG_LEN, 16'd2);
    push_req(16'h0040, 16'h0050, 2'b01);
    cpu_write(REG_CTRL, 16'h000B);
    wait_state(ST_WAIT_EOP, "t5_timeout");
    reset = 1'b1;
    #1;
    check("midrst_dreq", 34'(bus.dreq_), 34'd1);
    check("midrst_state", 34'(dbg_state), 34'(ST_IDLE));
    check("midrst_addr", {bus.dsaddr, bus.ddaddr, bus.dmode}, 34'd0);
    check("midrst_irq_rdata", {bus.irq, bus.rdata}, 34'd0);
    @(posedge clk); #1 reset = 1'b0;
    engine_en = 1'b1;
    cpu_read(REG_STATUS, 16'h0000, "midrst_status");

    // Abort after the second request
    cpu_write(REG_SRC, 16'h0010);
    cpu_write(REG_DST, 16'h0020);
    cpu_write(REG_LEN, 16'd5);
`ifdef DMACH_ABORT_EN
    for (int k = 0; k < 2; k++) push_req(16'h0010 + 16'(k), 16'h0020 + 16'(k), 2'b11);
`else
    for (int k = 0; k < 5; k++) push_req(16'h0010 + 16'(k), 16'h0020 + 16'(k), 2'b11);
`endif
    cpu_write(REG_CTRL, 16'h0007);
    @(posedge clk); #1;
    wait_state(ST_ISSUE, "t6_issue_timeout");
    cpu_write(REG_CTRL, 16'h0010);
    wait_state(ST_IDLE, "t6_timeout");
`ifdef DMACH_ABORT_EN
    cpu_read(REG_STATUS, 16'h0006, "abort_status");
    cpu_read(REG_REMAIN, 16'd3, "abort_remain");
`else
    cpu_read(REG_STATUS, 16'h0002, "abort_status");
    cpu_read(REG_REMAIN, 16'd0, "abort_remain");
`endif

    repeat (4) @(posedge clk);
    #1;
    check("rd_q_empty", 34'(exp_rd_q.size()), 34'd0);
    check("req_q_empty", 34'(exp_req_q.size()), 34'd0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
